// File: rtl/seq_always_pkg.sv
// Shared types and constants for the bit-serial word serializer.
// Mode bit indices select the shift order and the optional even-parity beat.
package seq_always_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  localparam int MODE_LSB_FIRST = 0;
  localparam int MODE_PARITY    = 1;

endpackage : seq_always_pkg

// File: rtl/seq_always_serializer.sv
// Parallel-to-serial converter: latches one word in IDLE, emits it one bit per
// accepted beat (MSB- or LSB-first), optionally followed by an even-parity beat.
module seq_always_serializer
  import seq_always_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] word_q;
  logic [1:0]       mode_q;
  logic [CW-1:0]    bit_idx_s;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  // State, beat counter and the latched word/mode; beats only advance on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      word_q  <= {WIDTH{1'b0}};
      mode_q  <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            word_q  <= in_data;
            mode_q  <= in_mode;
            cnt_q   <= {CW{1'b0}};
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (out_ready) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= mode_q[MODE_PARITY] ? ST_PARITY : ST_IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state only; in_ready is the sole handshake output.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b1;
    bit_idx_s = mode_q[MODE_LSB_FIRST] ? cnt_q : (CNT_LAST - cnt_q);
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_SHIFT: begin
        out_valid = 1'b1;
        out_bit   = word_q[bit_idx_s];
        // The data beat is final only when no parity beat follows it.
        out_last  = (cnt_q == CNT_LAST) && !mode_q[MODE_PARITY];
      end
      ST_PARITY: begin
        out_valid = 1'b1;
        out_bit   = even_parity(word_q);
        out_last  = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b1;
      end
    endcase
  end

endmodule : seq_always_serializer

// File: tb/tb_seq_always_serializer.sv
// Self-checking bench: table of words with expected beat streams fed through a
// scoreboard queue, plus hand sequences for stall, mid-word reset and busy input.
module tb_seq_always_serializer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic       out_last;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] sb_q[$];

  typedef struct {
    logic [3:0] data;
    logic [1:0] mode;
    int         n;
    logic [4:0] bits;
    logic [4:0] lasts;
  } vec_t;

  vec_t vecs[8];

  seq_always_serializer #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted beat is compared against the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got beat %b, expected none at %0t", out_bit, $time);
      end else begin
        logic [1:0] e;
        e = sb_q.pop_front();
        check("beat_bit", {31'd0, out_bit}, {31'd0, e[1]});
        check("beat_last", {31'd0, out_last}, {31'd0, e[0]});
      end
    end
  end

  task automatic send_start(input logic [3:0] d, input logic [1:0] m, input int n,
                            input logic [4:0] bits, input logic [4:0] lasts, input bit hold);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(posedge clk);
    for (int k = 0; k < n; k++) sb_q.push_back({bits[k], lasts[k]});
    @(negedge clk);
    if (!hold) begin
      in_valid = 1'b0;
      in_data  = 4'($urandom);
      in_mode  = 2'($urandom);
    end
    check("first_beat_latency", {31'd0, out_valid}, 32'd1);
    check("in_ready_in_word", {31'd0, in_ready}, 32'd0);
    check("busy_in_word", {31'd0, busy}, 32'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 60) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", sb_q.size(), 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
    check("in_ready_after_word", {31'd0, in_ready}, 32'd1);
    check("busy_after_word", {31'd0, busy}, 32'd0);
    check("out_valid_after_word", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{4'b1011, 2'b00, 4, 5'b01101, 5'b01000};
    vecs[1] = '{4'b1011, 2'b01, 4, 5'b01011, 5'b01000};
    vecs[2] = '{4'b1011, 2'b10, 5, 5'b11101, 5'b10000};
    vecs[3] = '{4'b0110, 2'b11, 5, 5'b00110, 5'b10000};
    vecs[4] = '{4'b1000, 2'b00, 4, 5'b00001, 5'b01000};
    vecs[5] = '{4'b1110, 2'b01, 4, 5'b01110, 5'b01000};
    vecs[6] = '{4'b0111, 2'b10, 5, 5'b11110, 5'b10000};
    vecs[7] = '{4'b0000, 2'b11, 5, 5'b00000, 5'b10000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'b0000;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_bit", {31'd0, out_bit}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send_start(vecs[i].data, vecs[i].mode, vecs[i].n, vecs[i].bits, vecs[i].lasts, 1'b0);
      drain();
    end

    // Backpressure after beat 2: beat must hold, then the stream resumes intact.
    send_start(4'b1011, 2'b00, 4, 5'b01101, 5'b01000, 1'b0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_bit", {31'd0, out_bit}, 32'd0);
      check("stall_last", {31'd0, out_last}, 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Reset after two beats aborts the word; the next word starts from its first bit.
    send_start(4'b1011, 2'b00, 4, 5'b01101, 5'b01000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("no_beats_after_abort", {31'd0, out_valid}, 32'd0);
    end
    send_start(4'b0110, 2'b00, 4, 5'b00110, 5'b01000, 1'b0);
    drain();

    // in_valid held with new data during SHIFT: old word completes, new one waits for IDLE.
    send_start(4'b1011, 2'b00, 4, 5'b01101, 5'b01000, 1'b1);
    in_data = 4'b0000;
    in_mode = 2'b11;
    drain();
    @(posedge clk);
    for (int k = 0; k < 5; k++) sb_q.push_back({1'b0, (k == 4) ? 1'b1 : 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    check("held_word_accepted_in_idle", {31'd0, busy}, 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_always_serializer

// File: doc/seq_always_serializer.md
SEQ_ALWAYS_SERIALIZER -- requirements
Module: seq_always_serializer

Interface
REQ-001 Parameter WIDTH, default 4, parallel word width in bits (>= 2).
REQ-002 Port clk  input  1  sole clock, all state on rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port in_valid  input  1  upstream word valid.
REQ-005 Port in_ready  output  1  block accepts a word this cycle.
REQ-006 Port in_data  input  WIDTH  parallel word.
REQ-007 Port in_mode  input  2  bit0 = LSB-first, bit1 = append even-parity beat.
REQ-008 Port out_valid  output  1  serial beat valid.
REQ-009 Port out_ready  input  1  downstream accepts the beat.
REQ-010 Port out_bit  output  1  serial data bit.
REQ-011 Port out_last  output  1  marks the final beat of a word.
REQ-012 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and PARITY, encoded in a 2-bit enum.
REQ-014 in_ready SHALL be high only in IDLE, decoded combinationally from state.
REQ-015 Word accept is in_valid && in_ready at edge N: latch in_data and in_mode, clear beat counter, go to SHIFT.
REQ-016 The first beat SHALL have out_valid high in cycle N+1, giving one-cycle latency.
REQ-017 In SHIFT, out_valid=1 and out_bit = latched bit [WIDTH-1-cnt] when mode bit0=0, or [cnt] when bit0=1.
REQ-018 A beat SHALL advance only on out_valid && out_ready; otherwise out_bit, out_last and cnt hold unchanged.
REQ-019 On the beat with cnt==WIDTH-1: go to PARITY if latched bit1=1, else go to IDLE.
REQ-020 out_last SHALL be high on that beat only when bit1=0.
REQ-021 In PARITY, out_valid=1, out_bit = XOR of the latched word, out_last=1; accept returns to IDLE.
REQ-022 cnt SHALL be $clog2(WIDTH) bits wide and SHALL never wrap; exit occurs at WIDTH-1.
REQ-023 in_valid, in_data and in_mode SHALL be ignored outside IDLE; the latched copy is authoritative.
REQ-024 IDLE SHALL last at least one cycle between words; the word period is WIDTH (+1) accepted beats plus 1 cycle.
REQ-025 out_ready high while out_valid is low SHALL have no effect.
REQ-026 Outputs SHALL be decoded from registered state only; there is no combinational in->out path except in_ready.

Reset
REQ-027 While rst_n is low: state=IDLE, cnt=0, latched word and mode = 0, out_valid=0, out_bit=0, out_last=0, busy=0, in_ready=1.
REQ-028 Reset asserted mid-word SHALL abort the word immediately, with no further beats of it after release.
REQ-029 The first edge after rst_n rises MAY accept a word.

Structure
REQ-030 Package seq_always_pkg SHALL hold the state enum type and the MODE_LSB_FIRST=0 / MODE_PARITY=1 bit-index constants.
REQ-031 The implementation SHALL be one always_ff for state, cnt and latches, plus one always_comb containing a case on state for the outputs.
REQ-032 No sub-module is required.

Verification (WIDTH=4, out_ready=1 unless stated)
REQ-033 in_data=4'b1011, mode=00, accepted at N -> out_bit 1,0,1,1 in N+1..N+4; out_last only at N+4; in_ready=1 at N+5.
REQ-034 in_data=4'b1011, mode=01 -> out_bit 1,1,0,1; out_last on the 4th beat.
REQ-035 in_data=4'b1011, mode=10 -> beats 1,0,1,1, then a parity beat 1 with out_last=1; the 4th beat has out_last=0.
REQ-036 mode=00, out_ready low for 2 cycles after beat 2 -> out_valid=1 and out_bit=0 held; the full sequence 1,0,1,1 is emitted with no skipped or duplicated beat.
REQ-037 rst_n pulsed low after 2 beats -> out_valid=0 and busy=0 asynchronously; the next word 4'b0110 emits 0,1,1,0 from the start.
REQ-038 in_valid held high with in_data changing to 4'b0000 during SHIFT -> the original word completes unchanged; the new word is accepted only in IDLE.
